// File: rtl/lfsr_stim_ctrl.sv
// lfsr_stim_ctrl: input conditioning and strobe generation for the LFSR
// generator/checker pair. It debounces the soft-reset and corrupt buttons,
// latches a non-zero seed, divides the clock into a valid strobe and arms a
// one-shot corruption that rides on a valid strobe.

// Debouncer for one synchronized button. It emits a single combinational
// press event (Mealy) on the cycle the press is accepted.
//   state        | meaning
//   IDLE         | released and stable, count = 0
//   PRESS_WAIT   | input high, counting stable high samples
//   PRESSED      | press accepted, waiting for input to drop
//   RELEASE_WAIT | input low, counting stable low samples
module lfsr_stim_debounce #(
    parameter int DEB_COUNT = 1000000
) (
    input  logic clk,
    input  logic i_rst,
    input  logic din,
    output logic press
);
    localparam int DW = $clog2(DEB_COUNT + 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [DW-1:0] cnt, cnt_nxt, cnt_inc;

    // The first qualifying sample already counts, so a level must hold for
    // exactly DEB_COUNT consecutive samples to be accepted.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press     = 1'b0;
        cnt_inc   = cnt + 1'b1;
        case (state)
            IDLE, PRESS_WAIT: begin
                if (!din) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_inc == DW'(DEB_COUNT)) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press     = 1'b1;
                end else begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = cnt_inc;
                end
            end
            PRESSED, RELEASE_WAIT: begin
                if (din) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt_inc == DW'(DEB_COUNT)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
endmodule

module lfsr_stim_ctrl #(
    parameter int DEB_COUNT = 1000000,
    parameter int DIV_COUNT = 50000000
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_btn,
    input  logic       i_corrupt,
    input  logic       i_run,
    input  logic [3:0] i_sw,
    output logic       o_valid,
    output logic       o_soft_reset,
    output logic [7:0] o_seed,
    output logic       o_corrupt
);
    localparam int VW = $clog2(DIV_COUNT);

    logic [1:0]    btn_sy, corrupt_sy, run_sy;
    logic [3:0]    sw_sy1, sw_s;
    logic          btn_press, corrupt_press;
    logic          run_s, strobe, armed;
    logic [VW-1:0] div_cnt;

    assign run_s = run_sy[1];

    // Two-flop synchronizers for every raw board input.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            btn_sy     <= '0;
            corrupt_sy <= '0;
            run_sy     <= '0;
            sw_sy1     <= '0;
            sw_s       <= '0;
        end else begin
            btn_sy     <= {btn_sy[0], i_btn};
            corrupt_sy <= {corrupt_sy[0], i_corrupt};
            run_sy     <= {run_sy[0], i_run};
            sw_sy1     <= i_sw;
            sw_s       <= sw_sy1;
        end
    end

    lfsr_stim_debounce #(.DEB_COUNT(DEB_COUNT)) u_deb_btn (
        .clk   (clk),
        .i_rst (i_rst),
        .din   (btn_sy[1]),
        .press (btn_press)
    );

    lfsr_stim_debounce #(.DEB_COUNT(DEB_COUNT)) u_deb_corrupt (
        .clk   (clk),
        .i_rst (i_rst),
        .din   (corrupt_sy[1]),
        .press (corrupt_press)
    );

    // A soft reset restarts the period, so it also swallows a coincident strobe.
    assign strobe = run_s && !btn_press && (div_cnt == VW'(DIV_COUNT - 1));

    // Valid divider: free-runs while run is set, parked at zero otherwise.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            div_cnt <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= strobe;
            if (btn_press || !run_s || strobe)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
        end
    end

    // Soft-reset pulse and seed capture; zero is the LFSR lock-up state.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_soft_reset <= 1'b0;
            o_seed       <= 8'h01;
        end else begin
            o_soft_reset <= btn_press;
            if (btn_press)
                o_seed <= (sw_s == 4'h0) ? 8'h01 : {4'h0, sw_s};
        end
    end

    // Corrupt arming: soft reset wins, then injection consumes the arm,
    // then a new press may arm. An arm set on a strobe edge waits for the next.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            armed     <= 1'b0;
            o_corrupt <= 1'b0;
        end else begin
            o_corrupt <= strobe && armed;
            if (btn_press)
                armed <= 1'b0;
            else if (strobe && armed)
                armed <= 1'b0;
            else if (corrupt_press)
                armed <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lfsr_stim_ctrl.sv
// Directed bench for lfsr_stim_ctrl with DEB_COUNT=4, DIV_COUNT=5.
module tb_lfsr_stim_ctrl;
    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_btn, i_corrupt, i_run;
    logic [3:0] i_sw;
    logic       o_valid, o_soft_reset, o_corrupt;
    logic [7:0] o_seed;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int bad_corrupt = 0;
    int last_seed   = -1;
    int valid_q[$];
    int sr_q[$];
    int cor_q[$];

    lfsr_stim_ctrl #(.DEB_COUNT(4), .DIV_COUNT(5)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_btn        (i_btn),
        .i_corrupt    (i_corrupt),
        .i_run        (i_run),
        .i_sw         (i_sw),
        .o_valid      (o_valid),
        .o_soft_reset (o_soft_reset),
        .o_seed       (o_seed),
        .o_corrupt    (o_corrupt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled mid-cycle.
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_valid) valid_q.push_back(cyc);
            if (o_soft_reset) begin
                sr_q.push_back(cyc);
                last_seed = int'(o_seed);
            end
            if (o_corrupt) begin
                cor_q.push_back(cyc);
                if (!o_valid) bad_corrupt++;
            end
        end
    end

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // which: 0 = valid, 1 = soft reset, 2 = corrupt
    function automatic int n_events(input int which, input int lo, input int hi);
        int n = 0;
        int q[$];
        q = (which == 0) ? valid_q : (which == 1) ? sr_q : cor_q;
        foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
        return n;
    endfunction

    function automatic int first_event(input int which, input int lo);
        int q[$];
        q = (which == 0) ? valid_q : (which == 1) ? sr_q : cor_q;
        foreach (q[i]) if (q[i] >= lo) return q[i];
        return -1;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic b, input logic c, output int t0);
        i_btn     = b;
        i_corrupt = c;
        t0        = cyc;
        cycles(8);
        i_btn     = 1'b0;
        i_corrupt = 1'b0;
        cycles(8);
    endtask

    initial begin
        int c0, t, found;

        i_rst = 1'b1; i_btn = 1'b0; i_corrupt = 1'b0; i_run = 1'b0; i_sw = 4'h0;
        cycles(3);
        check_val("rst_valid", int'(o_valid), 0);
        check_val("rst_soft_reset", int'(o_soft_reset), 0);
        check_val("rst_corrupt", int'(o_corrupt), 0);
        check_val("rst_seed", int'(o_seed), 8'h01);
        i_rst = 1'b0;
        i_sw  = 4'hA;
        cycles(3);

        // Clean press, held 20 cycles.
        c0 = cyc;
        i_btn = 1'b1;
        cycles(20);
        i_btn = 1'b0;
        cycles(15);
        check_val("clean_pulses", n_events(1, c0, cyc), 1);
        check_val("clean_pulse_cyc", first_event(1, c0), c0 + 6);
        check_val("clean_pulse_seed", last_seed, 8'h0A);
        check_val("clean_seed_held", int'(o_seed), 8'h0A);

        // Bounce 3 high / 1 low, then steady high with zero switches.
        i_sw = 4'h0;
        cycles(3);
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            i_btn = 1'b1;
            cycles(3);
            i_btn = 1'b0;
            cycles(1);
        end
        check_val("bounce_no_pulse", n_events(1, c0, cyc), 0);
        c0 = cyc;
        i_btn = 1'b1;
        cycles(15);
        i_btn = 1'b0;
        cycles(12);
        check_val("bounce_pulses", n_events(1, c0, cyc), 1);
        check_val("bounce_pulse_cyc", first_event(1, c0), c0 + 6);
        check_val("zero_sw_seed", last_seed, 8'h01);

        // Valid divider.
        c0 = cyc;
        i_run = 1'b1;
        cycles(18);
        check_val("div_strobes", n_events(0, c0, cyc), 3);
        check_val("div_first", first_event(0, c0), c0 + 7);
        check_val("div_period", first_event(0, c0 + 8), c0 + 12);
        i_run = 1'b0;
        cycles(3);
        c0 = cyc;
        cycles(15);
        check_val("run_off_strobes", n_events(0, c0, cyc), 0);
        c0 = cyc;
        i_run = 1'b1;
        i_sw  = 4'h3;
        cycles(9);
        check_val("run_restart_first", first_event(0, c0), c0 + 7);
        press(1'b1, 1'b0, t);
        cycles(4);
        check_val("btn_run_pulse_cyc", first_event(1, t), t + 6);
        check_val("btn_run_seed", last_seed, 8'h03);
        check_val("btn_restart_valid", first_event(0, t + 6), t + 11);

        // Corrupt one-shot: two presses while stopped, then run.
        i_run = 1'b0;
        cycles(4);
        press(1'b0, 1'b1, t);
        press(1'b0, 1'b1, t);
        c0 = cyc;
        i_run = 1'b1;
        cycles(25);
        check_val("oneshot_strobes", n_events(0, c0, cyc), 4);
        check_val("oneshot_count", n_events(2, c0, cyc), 1);
        check_val("oneshot_cyc", first_event(2, c0), c0 + 7);

        // Corrupt cancelled by a later soft reset.
        i_run = 1'b0;
        cycles(4);
        press(1'b0, 1'b1, t);
        press(1'b1, 1'b0, t);
        c0 = cyc;
        i_run = 1'b1;
        cycles(20);
        check_val("cancel_strobes", n_events(0, c0, cyc), 3);
        check_val("cancel_corrupt", n_events(2, c0, cyc), 0);

        // Soft reset and corrupt pressed together: soft reset wins.
        i_run = 1'b0;
        cycles(4);
        press(1'b1, 1'b1, t);
        check_val("simul_pulse_cyc", first_event(1, t), t + 6);
        c0 = cyc;
        i_run = 1'b1;
        cycles(20);
        check_val("simul_corrupt", n_events(2, c0, cyc), 0);
        check_val("corrupt_without_valid", bad_corrupt, 0);

        // Asynchronous reset in the middle of a valid strobe.
        found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            @(negedge clk);
            if (o_valid) found = 1;
        end
        check_val("strobe_before_reset", found, 1);
        check_val("seed_before_reset", int'(o_seed), 8'h03);
        i_rst = 1'b1;
        #1;
        check_val("async_valid", int'(o_valid), 0);
        check_val("async_soft_reset", int'(o_soft_reset), 0);
        check_val("async_corrupt", int'(o_corrupt), 0);
        check_val("async_seed", int'(o_seed), 8'h01);
        cycles(2);
        i_rst = 1'b0;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
